// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bridge: command byte layout,
// idle transmit value and the bridge FSM state encoding.
package spi_pkg;

  localparam int unsigned SPI_CMD_RD_BIT = 7;
  localparam logic [7:0]  SPI_IDLE_TX    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_ISSUE,
    ST_RD_LOAD,
    ST_RD_DATA
  } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a parameterized reset value.
module sync_2ff #(
  parameter int unsigned        WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder behind spi_slaver: decodes {R/W,addr}, drives a
// single-cycle register bus with auto-increment and returns read data on tx_byte.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter bit          AUTO_INC = 1'b1,
  parameter logic [7:0]  IDLE_TX  = SPI_IDLE_TX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_end
);

  logic              cs_sync;
  logic              cs_prev_q, cs_prev_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  logic              cs_fall, cs_rise;

  spi_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              busy_q, busy_d;
  logic              frame_end_q, frame_end_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d   (cs),
    .q   (cs_sync)
  );

  // The sync stages come out of reset at 1 regardless of the pin, so edges are
  // only trusted once the pipeline has flushed and cs has been seen high. This
  // keeps a reset in the middle of a frame from reopening that same frame.
  always_comb begin
    cs_prev_d = cs_sync;
    settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d   = armed_q | ((settle_q == 2'd2) & cs_sync);
    cs_fall   = armed_q &  cs_prev_q & ~cs_sync;
    cs_rise   = armed_q & ~cs_prev_q &  cs_sync;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tx_byte_d   = tx_byte_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd      = 1'b0;
    busy_d      = busy_q;
    frame_end_d = cs_rise;

    // Write address advances after the strobe so reg_addr is stable during it.
    if (reg_wr_q) begin
      addr_d = addr_q + ADDR_W'(AUTO_INC);
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_CMD;
          busy_d  = 1'b1;
        end
      end
      ST_CMD: begin
        if (rx_valid) begin
          addr_d  = rx_byte[ADDR_W-1:0];
          state_d = rx_byte[SPI_CMD_RD_BIT] ? ST_RD_ISSUE : ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_valid) begin
          reg_wr_d    = 1'b1;
          reg_wdata_d = DATA_W'(rx_byte);
        end
      end
      ST_RD_ISSUE: begin
        reg_rd  = ~cs_rise;
        state_d = ST_RD_LOAD;
      end
      ST_RD_LOAD: begin
        tx_byte_d = 8'(reg_rdata);
        state_d   = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rx_valid) begin
          addr_d  = addr_q + ADDR_W'(AUTO_INC);
          state_d = ST_RD_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame close wins over everything except the byte that finished with it.
    if (cs_rise) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      tx_byte_d = IDLE_TX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      tx_byte_q   <= IDLE_TX;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      cs_prev_q   <= cs_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      tx_byte_q   <= tx_byte_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      busy_q      <= busy_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign busy      = busy_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge with a 128x8 register model.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       frame_end;

  int errors = 0;
  int checks = 0;

  spi_reg_bridge #(
    .ADDR_W   (7),
    .DATA_W   (8),
    .AUTO_INC (1'b1),
    .IDLE_TX  (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_byte   (tx_byte),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (reg_wr) mem[reg_addr] <= reg_wdata;
    if (reg_rd) reg_rdata <= mem[reg_addr];
  end

  int unsigned wr_n = 0, rd_n = 0, fe_n = 0, overlap_n = 0;
  logic [6:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [6:0] rd_addr_log [64];

  always @(negedge clk) begin
    if (reg_wr && reg_rd) overlap_n++;
    if (reg_wr) begin
      wr_addr_log[wr_n[5:0]] = reg_addr;
      wr_data_log[wr_n[5:0]] = reg_wdata;
      wr_n++;
    end
    if (reg_rd) begin
      rd_addr_log[rd_n[5:0]] = reg_addr;
      rd_n++;
    end
    if (frame_end) fe_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cs_low();
    cs = 1'b0;
    ticks(4);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    ticks(6);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse_rx(b);
    ticks(7);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    ticks(3);
    checks++;
    if ({tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_end} !== {8'hFF, 7'h00, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: tx=%h addr=%h wdata=%h wr=%b rd=%b busy=%b fe=%b expected tx=ff addr=00 wdata=00 strobes/busy/fe=0",
               tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_end);
    end
    rst = 1'b0;
    ticks(5);
  endtask

  task automatic test_write_burst();
    int unsigned w0 = wr_n, f0 = fe_n;
    cs_low();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_open: got %b expected 1", busy); end
    send(8'h05); send(8'hA1); send(8'hB2);
    cs_high();
    checks++;
    if (wr_n - w0 !== 2) begin errors++; $display("FAIL wr_count: got %0d expected 2", wr_n - w0); end
    checks++;
    if ({wr_addr_log[w0], wr_data_log[w0]} !== {7'h05, 8'hA1}) begin
      errors++; $display("FAIL wr_first: got addr=%h data=%h expected 05/a1", wr_addr_log[w0], wr_data_log[w0]);
    end
    checks++;
    if ({wr_addr_log[w0+1], wr_data_log[w0+1]} !== {7'h06, 8'hB2}) begin
      errors++; $display("FAIL wr_second: got addr=%h data=%h expected 06/b2", wr_addr_log[w0+1], wr_data_log[w0+1]);
    end
    checks++;
    if (fe_n - f0 !== 1) begin errors++; $display("FAIL wr_frame_end: got %0d pulses expected 1", fe_n - f0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_closed: got %b expected 0", busy); end
  endtask

  task automatic test_read_burst();
    int unsigned r0;
    cs_low(); send(8'h10); send(8'h3C); send(8'hC3); cs_high();
    r0 = rd_n;
    cs_low();
    pulse_rx(8'h90);
    tick();
    checks++;
    if (tx_byte !== 8'hFF) begin errors++; $display("FAIL rd_tx_early: got %h expected ff", tx_byte); end
    tick();
    checks++;
    if (tx_byte !== 8'h3C) begin errors++; $display("FAIL rd_tx_first: got %h expected 3c", tx_byte); end
    ticks(5);
    pulse_rx(8'h00);
    tick();
    checks++;
    if (tx_byte !== 8'h3C) begin errors++; $display("FAIL rd_tx_hold: got %h expected 3c", tx_byte); end
    tick();
    checks++;
    if (tx_byte !== 8'hC3) begin errors++; $display("FAIL rd_tx_second: got %h expected c3", tx_byte); end
    ticks(5);
    send(8'h00);
    cs_high();
    checks++;
    if (rd_n - r0 !== 3) begin errors++; $display("FAIL rd_count: got %0d expected 3", rd_n - r0); end
    checks++;
    if ({rd_addr_log[r0], rd_addr_log[r0+1], rd_addr_log[r0+2]} !== {7'h10, 7'h11, 7'h12}) begin
      errors++; $display("FAIL rd_addrs: got %h %h %h expected 10 11 12", rd_addr_log[r0], rd_addr_log[r0+1], rd_addr_log[r0+2]);
    end
    checks++;
    if (tx_byte !== 8'hFF) begin errors++; $display("FAIL rd_tx_idle: got %h expected ff", tx_byte); end
  endtask

  task automatic test_wrap();
    int unsigned w0 = wr_n;
    cs_low(); send(8'h7F); send(8'h11); send(8'h22); cs_high();
    checks++;
    if ({wr_n - w0, wr_addr_log[w0], wr_data_log[w0], wr_addr_log[w0+1], wr_data_log[w0+1]} !==
        {32'd2, 7'h7F, 8'h11, 7'h00, 8'h22}) begin
      errors++;
      $display("FAIL wrap: got n=%0d %h=%h %h=%h expected n=2 7f=11 00=22",
               wr_n - w0, wr_addr_log[w0], wr_data_log[w0], wr_addr_log[w0+1], wr_data_log[w0+1]);
    end
  endtask

  task automatic test_abort();
    int unsigned r0 = rd_n, f0 = fe_n, w0, r1;
    cs_low();
    pulse_rx(8'h90);
    cs = 1'b1;
    ticks(6);
    checks++;
    if (rd_n - r0 > 1) begin errors++; $display("FAIL abort_rd_count: got %0d expected at most 1", rd_n - r0); end
    checks++;
    if ({tx_byte, busy} !== {8'hFF, 1'b0}) begin
      errors++; $display("FAIL abort_idle: got tx=%h busy=%b expected ff/0", tx_byte, busy);
    end
    checks++;
    if (fe_n - f0 !== 1) begin errors++; $display("FAIL abort_frame_end: got %0d expected 1", fe_n - f0); end
    w0 = wr_n; r1 = rd_n;
    ticks(20);
    checks++;
    if ({wr_n, rd_n} !== {w0, r1}) begin
      errors++; $display("FAIL abort_quiet: got wr=%0d rd=%0d expected wr=%0d rd=%0d", wr_n, rd_n, w0, r1);
    end
    cs_low(); send(8'h40); send(8'h99); cs_high();
    checks++;
    if ({wr_n - w0, wr_addr_log[w0], wr_data_log[w0]} !== {32'd1, 7'h40, 8'h99}) begin
      errors++; $display("FAIL abort_next_frame: got n=%0d %h=%h expected n=1 40=99", wr_n - w0, wr_addr_log[w0], wr_data_log[w0]);
    end
  endtask

  task automatic test_collision();
    int unsigned w0 = wr_n;
    cs_low();
    send(8'h30);
    cs = 1'b1;
    tick(); tick();
    pulse_rx(8'h55);
    checks++;
    if ({reg_wr, reg_wdata, reg_addr, frame_end, busy} !== {1'b1, 8'h55, 7'h30, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL collision: got wr=%b wdata=%h addr=%h fe=%b busy=%b expected 1/55/30/1/0",
               reg_wr, reg_wdata, reg_addr, frame_end, busy);
    end
    ticks(8);
    checks++;
    if ({wr_n - w0, busy} !== {32'd1, 1'b0}) begin
      errors++; $display("FAIL collision_after: got n=%0d busy=%b expected 1/0", wr_n - w0, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int unsigned w0 = wr_n;
    cs_low();
    send(8'h20);
    rst = 1'b1;
    tick();
    checks++;
    if ({tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_end} !== {8'hFF, 7'h00, 8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL midrst_state: tx=%h addr=%h wdata=%h wr=%b rd=%b busy=%b fe=%b expected ff/00/00/0/0/0/0",
               tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_end);
    end
    rst = 1'b0;
    ticks(4);
    send(8'hAB);
    checks++;
    if ({wr_n, busy} !== {w0, 1'b0}) begin
      errors++; $display("FAIL midrst_stale_byte: got wr=%0d busy=%b expected wr=%0d busy=0", wr_n, busy, w0);
    end
    cs_high();
    cs_low(); send(8'h21); send(8'h77); cs_high();
    checks++;
    if ({wr_n - w0, wr_addr_log[w0], wr_data_log[w0]} !== {32'd1, 7'h21, 8'h77}) begin
      errors++; $display("FAIL midrst_next_frame: got n=%0d %h=%h expected n=1 21=77", wr_n - w0, wr_addr_log[w0], wr_data_log[w0]);
    end
  endtask

  task automatic test_empty_frame();
    int unsigned w0 = wr_n, r0 = rd_n, f0 = fe_n;
    send(8'h85);
    checks++;
    if ({busy, wr_n, rd_n} !== {1'b0, w0, r0}) begin
      errors++; $display("FAIL idle_rx_ignored: got busy=%b wr=%0d rd=%0d expected 0/%0d/%0d", busy, wr_n, rd_n, w0, r0);
    end
    cs_low();
    cs_high();
    checks++;
    if ({fe_n - f0, wr_n, rd_n, busy} !== {32'd1, w0, r0, 1'b0}) begin
      errors++; $display("FAIL empty_frame: got fe=%0d wr=%0d rd=%0d busy=%b expected 1/%0d/%0d/0", fe_n - f0, wr_n, rd_n, busy, w0, r0);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_abort();
    test_collision();
    test_reset_mid_write();
    test_empty_frame();
    checks++;
    if (overlap_n !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_n); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
